// File: rtl/dlsc_rvh_fifo_pkg.sv
// rtl/dlsc_rvh_fifo_pkg.sv - shared sizing helpers for the RVH FIFO
package dlsc_rvh_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // count must represent 0..DEPTH inclusive
  function automatic int count_width(input int depth);
    return clog2(depth + 1);
  endfunction

  // a single-entry array still needs a 1-bit pointer
  function automatic int ptr_width(input int entries);
    return (clog2(entries) < 1) ? 1 : clog2(entries);
  endfunction

endpackage

// File: rtl/dlsc_rvh_fifo_ram_dp.sv
// rtl/dlsc_rvh_fifo_ram_dp.sv - 1-write/1-read storage array with asynchronous read
module dlsc_rvh_fifo_ram_dp #(
  parameter int DATA  = 32,
  parameter int WORDS = 15,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DATA-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [DATA-1:0] rd_data
);

  logic [DATA-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dlsc_rvh_fifo.sv
// rtl/dlsc_rvh_fifo.sv - ready/valid/hold FIFO with registered output, occupancy and almost-full
module dlsc_rvh_fifo
  import dlsc_rvh_fifo_pkg::*;
#(
  parameter int              DATA        = 32,
  parameter int              DEPTH       = 16,
  parameter int              ALMOST_FULL = DEPTH - 2,
  parameter logic [DATA-1:0] RESET       = {DATA{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          in_ready,
  input  logic                          in_valid,
  input  logic [DATA-1:0]               in_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA-1:0]               out_data,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          almost_full
);

  localparam int CW = count_width(DEPTH);
  localparam int AD = DEPTH - 1;
  localparam int PW = ptr_width(AD);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(ALMOST_FULL);
  localparam logic [PW-1:0] PTR_LAST = PW'(AD - 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_bad_param
    $error("dlsc_rvh_fifo: DEPTH must be a power of 2 >= 2 and ALMOST_FULL within 1..DEPTH");
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  logic            push;
  logic            pop;
  logic            arr_empty;
  logic            load_out;
  logic            direct;
  logic            wr_en;
  logic            rd_en;
  logic [CW-1:0]   count_next;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [DATA-1:0] rd_data;

  // The array holds count minus the output register; a word bypasses the array
  // only when the array is empty and the output register is free this edge.
  always_comb begin
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    arr_empty  = (count == {{(CW-1){1'b0}}, out_valid});
    load_out   = !out_valid || out_ready;
    direct     = push && arr_empty && load_out;
    wr_en      = push && !direct;
    rd_en      = load_out && !arr_empty;
    count_next = count + CW'(push) - CW'(pop);
  end

  dlsc_rvh_fifo_ram_dp #(
    .DATA  (DATA),
    .WORDS (AD),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= RESET;
      count       <= '0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      count       <= count_next;
      in_ready    <= (count_next < DEPTH_C);
      almost_full <= (count_next >= AF_C);
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        out_valid <= 1'b1;
        out_data  <= rd_data;
      end else if (direct) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (load_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
